bcd_seg_scan: RTL and testbench

BCD_SEG_SCAN -- requirements
Module: bcd_seg_scan

---
 rtl/bcd_seg_pkg.sv | 29 ++
 rtl/bcd_seg_dec.sv | 12 +
 rtl/bcd_seg_scan.sv | 81 ++++++++
 tb/tb_bcd_seg_scan.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_seg_pkg.sv
// Shared constants and types for the multiplexed BCD seven-segment scanner.
// Combinational definitions only; no timing or flow-control behaviour.
package bcd_seg_pkg;

    localparam int NUM_DIGITS = 4;

    typedef logic [1:0] digit_idx_t;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Index 15 is leftmost; codes 10-15 decode to blank.
    localparam logic [15:0][6:0] SEG_LUT = {
        SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK,
        7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
        7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic logic has_bad_digit(input logic [15:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (v[i*4 +: 4] > 4'd9) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

endpackage

// File: rtl/bcd_seg_dec.sv
// 4-bit BCD code to active-high seven-segment pattern (bit0=a .. bit6=g).
// Purely combinational, zero latency; no backpressure.
module bcd_seg_dec
    import bcd_seg_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);

    assign seg = SEG_LUT[code];

endmodule

// File: rtl/bcd_seg_scan.sv
// Four-digit multiplexed BCD display scanner; define BCD_SEG_SCAN_LZB_EN for leading-zero blanking.
// Outputs registered and advance one digit per SCAN_DIV cycles; load is always accepted (no backpressure).
module bcd_seg_scan
    import bcd_seg_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] bcd_in,
    output logic [6:0]  seg_out,
    output logic [3:0]  dig_sel,
    output logic        err
);

    localparam logic [15:0] PRE_TERM = 16'(SCAN_DIV - 1);

    logic [15:0] shadow;
    logic [15:0] pre_cnt;
    digit_idx_t  idx;
    digit_idx_t  nxt_idx;
    logic        tick;
    logic [3:0]  nxt_code;
    logic [6:0]  dec_seg;
    logic [6:0]  nxt_seg;

    assign tick     = (pre_cnt == PRE_TERM);
    assign nxt_idx  = idx + 2'd1;
    assign nxt_code = shadow[{nxt_idx, 2'b00} +: 4];

    bcd_seg_dec u_dec (
        .code (nxt_code),
        .seg  (dec_seg)
    );

`ifdef BCD_SEG_SCAN_LZB_EN
    logic lead_zero;

    // A digit is blanked only when it and every more-significant digit are zero.
    always_comb begin
        lead_zero = 1'b0;
        case (nxt_idx)
            2'd3:    lead_zero = (shadow[15:12] == 4'h0);
            2'd2:    lead_zero = (shadow[15:8] == 8'h00);
            2'd1:    lead_zero = (shadow[15:4] == 12'h000);
            default: lead_zero = 1'b0;
        endcase
    end

    assign nxt_seg = lead_zero ? SEG_BLANK : dec_seg;
`else
    assign nxt_seg = dec_seg;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow  <= 16'h0000;
            pre_cnt <= 16'h0000;
            idx     <= 2'd0;
            dig_sel <= 4'b0001;
            seg_out <= SEG_LUT[0];
            err     <= 1'b0;
        end else begin
            if (load) begin
                shadow <= bcd_in;
            end
            // Derived from the pre-edge shadow, so validity lags a load by one cycle.
            err <= has_bad_digit(shadow);
            if (tick) begin
                pre_cnt <= 16'h0000;
                idx     <= nxt_idx;
                dig_sel <= 4'(4'b0001 << nxt_idx);
                seg_out <= nxt_seg;
            end else begin
                pre_cnt <= pre_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Self-checking bench: SCAN_DIV=4 and SCAN_DIV=1 instances against a time-based reference model.
module tb_bcd_seg_scan;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        load = 1'b0;
    logic [15:0] bcd_in = 16'h0000;
    logic [6:0]  seg4, seg1;
    logic [3:0]  dig4, dig1;
    logic        err4, err1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bcd_seg_scan #(.SCAN_DIV(4)) dut (
        .clk(clk), .reset(reset), .load(load), .bcd_in(bcd_in),
        .seg_out(seg4), .dig_sel(dig4), .err(err4)
    );

    bcd_seg_scan #(.SCAN_DIV(1)) dut1 (
        .clk(clk), .reset(reset), .load(load), .bcd_in(bcd_in),
        .seg_out(seg1), .dig_sel(dig1), .err(err1)
    );

    // ---------------- reference model ----------------
    function automatic logic [6:0] dec_ref(input logic [3:0] c);
        case (c)
            4'd0: return 7'h3F;  4'd1: return 7'h06;  4'd2: return 7'h5B;
            4'd3: return 7'h4F;  4'd4: return 7'h66;  4'd5: return 7'h6D;
            4'd6: return 7'h7D;  4'd7: return 7'h07;  4'd8: return 7'h7F;
            4'd9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    function automatic logic [6:0] show_ref(input logic [15:0] v, input int n);
`ifdef BCD_SEG_SCAN_LZB_EN
        if (n > 0 && (v >> (4 * n)) == 16'h0000) return 7'h00;
`endif
        return dec_ref(v[n*4 +: 4]);
    endfunction

    function automatic logic bad_ref(input logic [15:0] v);
        for (int i = 0; i < 4; i++) if (v[i*4 +: 4] > 4'd9) return 1'b1;
        return 1'b0;
    endfunction

    int          divs [2] = '{4, 1};
    logic [15:0] m_shadow [2];
    int          m_t [2];
    int          m_idx [2];
    logic [6:0]  m_seg [2];
    logic        m_err [2];

    // Digit shown after edge t (edges counted from reset release) is ((t+1)/DIV) mod 4,
    // refreshed only on edges where t mod DIV == DIV-1, using the shadow before that edge.
    always @(posedge clk or negedge reset) begin : model
        logic [15:0] old;
        for (int k = 0; k < 2; k++) begin
            if (!reset) begin
                m_shadow[k] = 16'h0000;
                m_t[k]      = 0;
                m_idx[k]    = 0;
                m_seg[k]    = 7'h3F;
                m_err[k]    = 1'b0;
            end else begin
                old = m_shadow[k];
                if (m_t[k] % divs[k] == divs[k] - 1) begin
                    m_idx[k] = ((m_t[k] + 1) / divs[k]) % 4;
                    m_seg[k] = show_ref(old, m_idx[k]);
                end
                m_err[k] = bad_ref(old);
                if (load) m_shadow[k] = bcd_in;
                m_t[k] = m_t[k] + 1;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        check("seg4_model", 32'(seg4), 32'(m_seg[0]));
        check("dig4_model", 32'(dig4), 32'(1 << m_idx[0]));
        check("err4_model", 32'(err4), 32'(m_err[0]));
        check("seg1_model", 32'(seg1), 32'(m_seg[1]));
        check("dig1_model", 32'(dig1), 32'(1 << m_idx[1]));
        check("err1_model", 32'(err1), 32'(m_err[1]));
    endtask

    task automatic do_load(input logic [15:0] v);
        load = 1'b1;
        bcd_in = v;
        step();
        load = 1'b0;
    endtask

    task automatic wait_tick(output int n);
        logic [3:0] prev;
        prev = dig4;
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (dig4 != prev) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic wait_digit(input int d);
        int n;
        for (int i = 0; i < 6; i++) begin
            wait_tick(n);
            if (n < 0 || dig4 == 4'(1 << d)) break;
        end
        check("wait_digit", 32'(dig4), 32'(1 << d));
    endtask

    typedef struct {
        logic [15:0] bcd;
        int          idx;
        logic [6:0]  seg;
        logic        err;
    } vec_t;

    vec_t vecs [12];

    initial begin
        int n;
        logic [3:0] prev;
        logic [6:0] lz_hi;

        lz_hi = 7'h3F;
`ifdef BCD_SEG_SCAN_LZB_EN
        lz_hi = 7'h00;
`endif
        vecs[0]  = '{16'h9876, 0, 7'h7D, 1'b0};
        vecs[1]  = '{16'h9876, 3, 7'h6F, 1'b0};
        vecs[2]  = '{16'h5555, 2, 7'h6D, 1'b0};
        vecs[3]  = '{16'h0F08, 0, 7'h7F, 1'b1};
        vecs[4]  = '{16'h0F08, 2, 7'h00, 1'b1};
        vecs[5]  = '{16'hC000, 3, 7'h00, 1'b1};
        vecs[6]  = '{16'hC000, 0, 7'h3F, 1'b1};
        vecs[7]  = '{16'h0003, 1, lz_hi, 1'b0};
        vecs[8]  = '{16'h1000, 1, 7'h3F, 1'b0};
        vecs[9]  = '{16'h0004, 0, 7'h66, 1'b0};
        vecs[10] = '{16'h0090, 3, lz_hi, 1'b0};
        vecs[11] = '{16'h0090, 1, 7'h6F, 1'b0};

        // Reset state
        step();
        step();
        check("rst_dig", 32'(dig4), 32'h1);
        check("rst_seg", 32'(seg4), 32'h3F);
        check("rst_err", 32'(err4), 32'h0);
        check("rst_dig1", 32'(dig1), 32'h1);

        // Release and load 1234 on the first edge: ticks at edges 4, 8, 12, 16
        reset = 1'b1;
        do_load(16'h1234);
        wait_tick(n);
        check("first_tick_gap", 32'(n), 32'd3);
        check("s1234_dig1", 32'(dig4), 32'h2);
        check("s1234_seg1", 32'(seg4), 32'h4F);
        wait_tick(n);
        check("s1234_gap", 32'(n), 32'd4);
        check("s1234_seg2", 32'(seg4), 32'h5B);
        wait_tick(n);
        check("s1234_seg3", 32'(seg4), 32'h06);
        check("s1234_dig3", 32'(dig4), 32'h8);
        wait_tick(n);
        check("s1234_seg0", 32'(seg4), 32'h66);
        check("s1234_dig0", 32'(dig4), 32'h1);

        // Table-driven digit checks
        for (int i = 0; i < 12; i++) begin
            do_load(vecs[i].bcd);
            wait_digit(vecs[i].idx);
            check("vec_seg", 32'(seg4), 32'(vecs[i].seg));
            check("vec_err", 32'(err4), 32'(vecs[i].err));
        end

        // err timing: follows the shadow one cycle after the load edge
        do_load(16'h00A5);
        check("err_same_edge", 32'(err4), 32'h0);
        step();
        check("err_set", 32'(err4), 32'h1);
        wait_digit(1);
        check("a5_digit1_blank", 32'(seg4), 32'h00);
        do_load(16'h0005);
        check("err_hold", 32'(err4), 32'h1);
        step();
        check("err_clear", 32'(err4), 32'h0);

        // Load coinciding with a tick: old value first, new value next tick
        do_load(16'h8888);
        wait_tick(n);
        step();
        step();
        step();
        prev = dig4;
        do_load(16'h1111);
        check("coinc_tick_moved", 32'(dig4 != prev), 32'h1);
        check("coinc_old_seg", 32'(seg4), 32'h7F);
        wait_tick(n);
        check("coinc_gap", 32'(n), 32'd4);
        check("coinc_new_seg", 32'(seg4), 32'h06);

        // Leading-zero behaviour for 0070
        do_load(16'h0070);
        wait_digit(3);
        check("lz_d3", 32'(seg4), 32'(lz_hi));
        wait_digit(0);
        check("lz_d0", 32'(seg4), 32'h3F);
        wait_digit(1);
        check("lz_d1", 32'(seg4), 32'h07);
        wait_digit(2);
        check("lz_d2", 32'(seg4), 32'(lz_hi));

        // Async reset mid-slot at digit 2
        do_load(16'h00F0);
        step();
        wait_digit(2);
        step();
        check("pre_rst_err", 32'(err4), 32'h1);
        reset = 1'b0;
        #1;
        check("async_rst_dig", 32'(dig4), 32'h1);
        check("async_rst_seg", 32'(seg4), 32'h3F);
        check("async_rst_err", 32'(err4), 32'h0);
        step();
        reset = 1'b1;
        wait_tick(n);
        check("post_rst_gap", 32'(n), 32'd4);
        check("post_rst_dig", 32'(dig4), 32'h2);
        check("post_rst_seg", 32'(seg4), 32'(show_ref(16'h0000, 1)));

        // SCAN_DIV=1 rotates every cycle
        for (int i = 0; i < 100; i++) begin
            prev = dig1;
            step();
            check("div1_onehot", 32'($onehot(dig1)), 32'h1);
            check("div1_rotate", 32'(dig1), 32'({prev[2:0], prev[3]}));
        end

        // Randomized traffic, including occasional async resets
        for (int i = 0; i < 400; i++) begin
            load = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 0)
                bcd_in = 16'($urandom);
            else
                bcd_in = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                          4'($urandom_range(0, 2) * 0), 4'($urandom_range(0, 9))};
            if ($urandom_range(0, 79) == 0) begin
                reset = 1'b0;
                #1;
                check("rnd_rst_dig", 32'(dig4), 32'h1);
                step();
                reset = 1'b1;
            end else begin
                step();
            end
        end
        load = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
